// File: rtl/rx_flit_receiver.sv
// rx_flit_receiver: four-phase RX flit capture, packet framing from the header
// length byte, and a valid/ready word stream with sop/eop toward the PC buffer.
// Optional watchdog abort: define RX_TIMEOUT_EN.
module rx_flit_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX_REQ,
  input  logic [15:0] RX_DATA,
  output logic        RX_ACK,
  output logic        RECE_DONE,
  output logic [15:0] pkt_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic [15:0] pkt_cnt,
  output logic        rx_abort
);

  localparam int unsigned FLIT_W = 16;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_HIGH = 2'd2
  } state_e;

  state_e              state, state_d;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                req_s;
  logic                buf_free;
  logic [LEN_W-1:0]    remaining, remaining_d;
  logic                ack_d, done_d, valid_d, sop_d, eop_d;
  logic [FLIT_W-1:0]   data_d;
  logic [CNT_W-1:0]    cnt_d;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned WDOG_W = 16;
  logic [WDOG_W-1:0]   wdog, wdog_d;
  logic                abort_d;
`endif

  assign req_s    = req_sync[SYNC_STAGES-1];
  assign buf_free = !pkt_valid || pkt_ready;

  // RX_REQ synchroniser; only req_s is seen by the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_sync <= '0;
    else     req_sync <= {req_sync[SYNC_STAGES-2:0], RX_REQ};
  end

  // Next-state and next-output logic for the handshake/framing FSM
  always_comb begin
    state_d     = state;
    ack_d       = RX_ACK;
    done_d      = RECE_DONE;
    data_d      = pkt_data;
    valid_d     = pkt_valid && !pkt_ready;
    sop_d       = pkt_sop;
    eop_d       = pkt_eop;
    remaining_d = remaining;
    cnt_d       = pkt_cnt;
`ifdef RX_TIMEOUT_EN
    abort_d     = 1'b0;
    wdog_d      = '0;
`endif
    case (state)
      IDLE: begin
        done_d = 1'b1;
        ack_d  = 1'b0;
        if (req_s && buf_free) begin
          data_d      = RX_DATA;
          valid_d     = 1'b1;
          sop_d       = 1'b1;
          eop_d       = (RX_DATA[LEN_W-1:0] == '0);
          remaining_d = RX_DATA[LEN_W-1:0];
          ack_d       = 1'b1;
          done_d      = 1'b0;
          state_d     = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        ack_d = 1'b1;
        if (!req_s) begin
          ack_d = 1'b0;
          if (remaining == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = pkt_cnt + CNT_W'(1);
          end else begin
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        done_d = 1'b0;
        if (req_s && buf_free) begin
          data_d      = RX_DATA;
          valid_d     = 1'b1;
          sop_d       = 1'b0;
          eop_d       = (remaining == LEN_W'(1));
          remaining_d = remaining - LEN_W'(1);
          ack_d       = 1'b1;
          state_d     = WAIT_LOW;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        done_d  = 1'b1;
      end
    endcase
`ifdef RX_TIMEOUT_EN
    // Watchdog: count stalled cycles in the wait states, abort the packet on expiry
    if (state != IDLE && state_d == state) begin
      if (wdog == WDOG_W'(TIMEOUT - 1)) begin
        state_d     = IDLE;
        ack_d       = 1'b0;
        done_d      = 1'b1;
        remaining_d = '0;
        abort_d     = 1'b1;
      end else begin
        wdog_d = wdog + WDOG_W'(1);
      end
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      RX_ACK    <= 1'b0;
      RECE_DONE <= 1'b1;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      pkt_sop   <= 1'b0;
      pkt_eop   <= 1'b0;
      remaining <= '0;
      pkt_cnt   <= '0;
    end else begin
      state     <= state_d;
      RX_ACK    <= ack_d;
      RECE_DONE <= done_d;
      pkt_data  <= data_d;
      pkt_valid <= valid_d;
      pkt_sop   <= sop_d;
      pkt_eop   <= eop_d;
      remaining <= remaining_d;
      pkt_cnt   <= cnt_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  // Watchdog counter and one-cycle abort pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog     <= '0;
      rx_abort <= 1'b0;
    end else begin
      wdog     <= wdog_d;
      rx_abort <= abort_d;
    end
  end
`else
  assign rx_abort = 1'b0;
`endif

endmodule

// File: doc/rx_flit_receiver.md
Name: rx_flit_receiver

Overview:
- Sits directly downstream of the four-direction receive selector and consumes its muxed RX_REQ/RX_DATA/RX_ACK four-phase channel.
- Synchronises RX_REQ, captures 16-bit flits, and frames them into packets from a header length field.
- Presents packets as a valid/ready word stream with sop/eop toward the PC-side buffer.
- Drives RECE_DONE back to the selector so the receive direction only switches between packets.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the RX_REQ synchroniser (min 2).
- TIMEOUT, 1024, idle-cycle limit for the watchdog; used only when RX_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- RX_REQ  in  1  four-phase request from the direction selector.
- RX_DATA  in  16  flit data; stable while RX_REQ is high.
- RX_ACK  out  1  four-phase acknowledge, registered.
- RECE_DONE  out  1  high when idle between packets; the selector may switch direction only while this is high.
- pkt_data  out  16  output word.
- pkt_valid  out  1  pkt_data is valid.
- pkt_ready  in  1  downstream accepts the word.
- pkt_sop  out  1  word is the packet header flit.
- pkt_eop  out  1  word is the last flit of the packet.
- pkt_cnt  out  16  count of completed packets; wraps from 0xFFFF to 0.
- rx_abort  out  1  one-cycle pulse on watchdog abort; tied 0 without the macro.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All flops clear on rst assertion.
- Reset values: RX_ACK=0, RECE_DONE=1, pkt_valid=0, pkt_data=0, pkt_sop=0, pkt_eop=0, pkt_cnt=0, rx_abort=0, state=IDLE, remaining=0, synchroniser=0.
- Synchroniser: req_s is RX_REQ through SYNC_STAGES flip-flops. All FSM decisions use req_s only.
- Buffer free condition: buf_free = !pkt_valid || pkt_ready.
- Word transfer: a word transfers when pkt_valid && pkt_ready. pkt_valid then clears unless a new flit loads in the same cycle; a simultaneous drain and load is legal and loses nothing.
- IDLE: RECE_DONE=1, RX_ACK=0.
  - On req_s=1 && buf_free, load the header flit: pkt_data<=RX_DATA, pkt_valid<=1, pkt_sop<=1, remaining<=RX_DATA[7:0].
  - pkt_eop<=1 iff RX_DATA[7:0]==0.
  - Set RX_ACK<=1 and RECE_DONE<=0, then go to WAIT_LOW.
  - If !buf_free, stay in IDLE with RX_ACK=0; this is the backpressure mechanism.
- WAIT_LOW: RX_ACK held at 1.
  - On req_s=0, set RX_ACK<=0.
  - If remaining==0: go to IDLE, RECE_DONE<=1, pkt_cnt<=pkt_cnt+1.
  - Otherwise go to WAIT_HIGH.
- WAIT_HIGH: RECE_DONE=0.
  - On req_s=1 && buf_free, load a body flit: pkt_data<=RX_DATA, pkt_valid<=1, pkt_sop<=0, pkt_eop<=(remaining==1), remaining<=remaining-1.
  - Set RX_ACK<=1 and go to WAIT_LOW.
- Latency: with the buffer free, RX_ACK and pkt_valid rise on the SYNC_STAGES-th rising edge after the first edge that samples RX_REQ=1. RX_ACK falls SYNC_STAGES edges after RX_REQ is first sampled low.
- Packet framing: remaining is 8 bits, so a packet is 1..256 flits. The header is always emitted as the sop word.
- Reset mid-packet: RX_ACK drops immediately. The partial packet is discarded, pkt_cnt is not incremented, and the FSM restarts in IDLE. The next req_s=1 is treated as a header.
- Direction hold: RECE_DONE is low from header capture until the final flit's four-phase cycle completes, so the upstream direction cannot change mid-packet.

Optional Feature:
- Macro name: RX_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts clk cycles spent in WAIT_LOW or WAIT_HIGH without a state change.
  - It clears on every state transition.
  - On reaching TIMEOUT: RX_ACK<=0, state<=IDLE, RECE_DONE<=1, rx_abort pulses for 1 cycle, pkt_cnt is unchanged.
  - Flits already emitted stay emitted; the pending pkt_valid word is still delivered.
- Undefined: no watchdog; the FSM waits indefinitely and rx_abort is constant 0.

Test Plan:
- Single-flit packet: header 0x5A00 with four-phase handshake, pkt_ready=1 -> one word 0x5A00 with sop=1 and eop=1; RX_ACK rises 2 edges after REQ; RECE_DONE returns to 1; pkt_cnt=1.
- Multi-flit packet: header 0x0003 then 0x1111, 0x2222, 0x3333 -> 4 words in order; sop only on 0x0003; eop only on 0x3333; RECE_DONE=0 from header capture until the last ACK falls; pkt_cnt=1.
- Backpressure: pkt_ready=0 for 10 cycles while the header word is pending, then the body REQ rises -> RX_ACK stays 0 throughout; body flit loads on the cycle pkt_ready=1; no word lost or duplicated.
- Mid-packet reset: header 0x0002 and one body flit, then assert rst for 3 cycles -> RX_ACK=0 and pkt_valid=0 immediately; a following header 0x0000 is received as a new packet; pkt_cnt=1.
- Watchdog with RX_TIMEOUT_EN, TIMEOUT=16: header 0x0002, then REQ held low -> rx_abort pulses once 16 cycles after entering WAIT_HIGH; RECE_DONE=1; pkt_cnt=0.
- Counter wrap: preload via 65536 single-flit packets, or force pkt_cnt=0xFFFF and send one packet -> pkt_cnt=0x0000.
